mem_arbiter: RTL

//  Shares one single-port unified memory between the fetch stage (IF port) and the

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/arb_watchdog.sv | 30 +++
 rtl/mem_arbiter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the IF/DM unified-memory arbiter.
// Imported by mem_arbiter and arb_watchdog.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_DM
  } arb_owner_t;

  localparam int DEF_AW           = 32;
  localparam int DEF_DW           = 32;
  localparam int DEF_TIMEOUT      = 16;
  localparam int DEF_MAX_DM_BURST = 4;

endpackage

// File: rtl/arb_watchdog.sv
// Response watchdog: counts WAIT cycles from zero after a clear.
// expired is high in the cycle the count sits at TIMEOUT-1.
module arb_watchdog
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable && cnt != LAST) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = enable && (cnt == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// IF/DM arbiter for one single-port memory: IDLE->ISSUE->WAIT->RESP.
// Define ARB_FETCH_GUARD_EN to cap consecutive DM grants that starve IF.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_AW,
  parameter int DATA_WIDTH    = DEF_DW,
  parameter int TIMEOUT       = DEF_TIMEOUT
`ifdef ARB_FETCH_GUARD_EN
  ,
  parameter int MAX_DM_BURST  = DEF_MAX_DM_BURST
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      if_req,
  input  logic [ADDRESS_WIDTH-1:0]  if_addr,
  output logic [DATA_WIDTH-1:0]     if_rdata,
  output logic                      if_ack,
  input  logic                      dm_req,
  input  logic                      dm_we,
  input  logic [ADDRESS_WIDTH-1:0]  dm_addr,
  input  logic [DATA_WIDTH-1:0]     dm_wdata,
  input  logic [DATA_WIDTH/8-1:0]   dm_be,
  output logic [DATA_WIDTH-1:0]     dm_rdata,
  output logic                      dm_ack,
  output logic                      err,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDRESS_WIDTH-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic [DATA_WIDTH/8-1:0]   mem_be,
  input  logic                      mem_rvalid,
  input  logic [DATA_WIDTH-1:0]     mem_rdata
);

  localparam int BW = DATA_WIDTH / 8;

  arb_state_t state_q, state_d;
  arb_owner_t owner_q, owner_d;

  logic                     req_d;
  logic                     we_d;
  logic [ADDRESS_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0]    wdata_d;
  logic [BW-1:0]            be_d;
  logic                     if_ack_d;
  logic                     dm_ack_d;
  logic [DATA_WIDTH-1:0]    if_rdata_d;
  logic [DATA_WIDTH-1:0]    dm_rdata_d;
  logic                     err_d;
  logic [DATA_WIDTH-1:0]    rd;
  logic                     wd_clr;
  logic                     wd_en;
  logic                     expired;
  logic                     grant_dm;

  arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wd (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clr),
    .enable  (wd_en),
    .expired (expired)
  );

`ifdef ARB_FETCH_GUARD_EN
  localparam int GW = $clog2(MAX_DM_BURST + 1);

  logic [GW-1:0] burst_q, burst_d;
  logic          force_if;

  // Only DM grants that passed over a waiting fetch count toward the cap.
  assign force_if = if_req && (burst_q == GW'(MAX_DM_BURST));
  assign grant_dm = dm_req && !force_if;

  always_comb begin
    burst_d = burst_q;
    if (state_q == IDLE) begin
      if (grant_dm) begin
        burst_d = if_req ? burst_q + 1'b1 : '0;
      end else if (if_req) begin
        burst_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      burst_q <= '0;
    end else begin
      burst_q <= burst_d;
    end
  end
`else
  assign grant_dm = dm_req;
`endif

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    req_d      = 1'b0;
    we_d       = mem_we;
    addr_d     = mem_addr;
    wdata_d    = mem_wdata;
    be_d       = mem_be;
    if_ack_d   = 1'b0;
    dm_ack_d   = 1'b0;
    if_rdata_d = '0;
    dm_rdata_d = '0;
    err_d      = 1'b0;
    rd         = '0;
    wd_clr     = 1'b1;
    wd_en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_dm) begin
          state_d = ISSUE;
          owner_d = OWN_DM;
          req_d   = 1'b1;
          we_d    = dm_we;
          addr_d  = dm_addr;
          wdata_d = dm_wdata;
          be_d    = dm_be;
        end else if (if_req) begin
          state_d = ISSUE;
          owner_d = OWN_IF;
          req_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = if_addr;
          wdata_d = '0;
          be_d    = '1;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        wd_clr = 1'b0;
        wd_en  = 1'b1;
        // A response in the last watchdog cycle still counts as good.
        if (mem_rvalid || expired) begin
          state_d = RESP;
          err_d   = !mem_rvalid;
          if (mem_rvalid && !mem_we) begin
            rd = mem_rdata;
          end
          if (owner_q == OWN_DM) begin
            dm_ack_d   = 1'b1;
            dm_rdata_d = rd;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = rd;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= OWN_IF;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      mem_req   <= req_d;
      mem_we    <= we_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      mem_be    <= be_d;
      if_ack    <= if_ack_d;
      dm_ack    <= dm_ack_d;
      if_rdata  <= if_rdata_d;
      dm_rdata  <= dm_rdata_d;
      err       <= err_d;
    end
  end

endmodule
